// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prog_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } ld_state_e;

    // Error codes reported on err_code
    typedef enum logic [1:0] {
        LD_ERR_NONE    = 2'b00,
        LD_ERR_LEN     = 2'b01,
        LD_ERR_CSUM    = 2'b10,
        LD_ERR_TIMEOUT = 2'b11
    } ld_err_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = 2;

    // States in which a frame is being received
    function automatic logic is_busy(input ld_state_e s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/prog_loader_asm.sv
// Byte-to-word assembler: big-endian shift register, byte-in-word counter, 8-bit running checksum.
// Latency: word_nxt/word_done are combinational on the 4th byte; state updates on the clock edge.
// Backpressure: none; every byte_vld is consumed in the cycle it is presented.
module prog_loader_asm
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              clr,
    input  logic              byte_vld,
    input  logic [7:0]        byte_dat,
    output logic              word_done,
    output logic [DATA_W-1:0] word_nxt,
    output logic [7:0]        csum
);

    // Only the three older bytes need storing; the newest byte arrives on byte_dat.
    logic [DATA_W-9:0]     shift_q, shift_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]            csum_q, csum_d;

    assign word_nxt  = {shift_q, byte_dat};
    assign word_done = byte_vld && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    assign csum      = csum_q;

    // Shift the byte in MSB-first, advance the byte position, accumulate the checksum
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        if (clr) begin
            shift_d = '0;
            cnt_d   = '0;
            csum_d  = '0;
        end else if (byte_vld) begin
            shift_d = word_nxt[DATA_W-9:0];
            cnt_d   = cnt_q + BYTE_CNT_W'(1);
            csum_d  = csum_q + byte_dat;
        end
    end

    // Assembler state registers
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            shift_q <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: 16-bit word-count header, big-endian data words, checksum byte -> instruction memory.
// Latency: mem_we one cycle after the 4th byte of a word; done/err one cycle after the deciding byte.
// Backpressure: none; the byte stream cannot be stalled, a gap of TIMEOUT cycles ends the load with an error.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 2048,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [15:0]     LEN_MAX  = 16'(DEPTH);

    ld_state_e         state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    ld_err_e           code_q, code_d;

    logic              busy_now;
    logic              can_start;
    logic              asm_clr;
    logic              asm_vld;
    logic              word_done;
    logic [DATA_W-1:0] word_nxt;
    logic [7:0]        csum;
    logic [7:0]        csum_fin;
    logic [15:0]       len_rx;
    logic              last_word;

    assign busy_now  = is_busy(state_q);
    assign can_start = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
    // Assembler is cleared whenever a new load begins or a load is abandoned
    assign asm_clr   = abort || (start && can_start);
    assign asm_vld   = !abort && rx_valid && (state_q == ST_DATA);
    assign csum_fin  = csum + rx_data;
    assign len_rx    = {len_hi_q, rx_data};
    assign last_word = (16'(word_idx_q) == (len_q - 16'd1));

    prog_loader_asm #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clk       (clk),
        .reset_    (reset_),
        .clr       (asm_clr),
        .byte_vld  (asm_vld),
        .byte_dat  (rx_data),
        .word_done (word_done),
        .word_nxt  (word_nxt),
        .csum      (csum)
    );

    // Next-state logic: abort first, then frame parsing, then the inter-byte timeout
    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        tmo_d       = tmo_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = done_q;
        err_d       = err_q;
        code_d      = code_q;

        if (abort) begin
            state_d    = ST_IDLE;
            done_d     = 1'b0;
            err_d      = 1'b0;
            code_d     = LD_ERR_NONE;
            word_idx_d = '0;
            tmo_d      = '0;
        end else begin
            if (busy_now) begin
                tmo_d = rx_valid ? '0 : (tmo_q + TMO_W'(1));
            end

            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_d    = ST_LEN_HI;
                        done_d     = 1'b0;
                        err_d      = 1'b0;
                        code_d     = LD_ERR_NONE;
                        word_idx_d = '0;
                        tmo_d      = '0;
                    end
                end
                ST_LEN_HI: begin
                    if (rx_valid) begin
                        len_hi_d = rx_data;
                        state_d  = ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (rx_valid) begin
                        len_d = len_rx;
                        if ((len_rx != 16'd0) && (len_rx <= LEN_MAX)) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                            code_d  = LD_ERR_LEN;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_done) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_idx_q;
                        mem_wdata_d = word_nxt;
                        if (last_word) begin
                            state_d = ST_CSUM;
                        end else begin
                            word_idx_d = word_idx_q + ADDR_W'(1);
                        end
                    end
                end
                ST_CSUM: begin
                    if (rx_valid) begin
                        if (csum_fin == 8'h00) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                            code_d  = LD_ERR_CSUM;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // A byte arriving in the expiry cycle keeps the load alive
            if (busy_now && !rx_valid && (tmo_q == TMO_LAST)) begin
                state_d = ST_ERR;
                err_d   = 1'b1;
                code_d  = LD_ERR_TIMEOUT;
            end
        end

        busy_d = is_busy(state_d);
    end

    // FSM, counters and registered outputs
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= ST_IDLE;
            len_hi_q    <= '0;
            len_q       <= '0;
            word_idx_q  <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= LD_ERR_NONE;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed frames plus random frames against a frame-position reference model.
// Latency: model predicts every output one clock after the inputs it sees.
// Backpressure: none; bytes are offered with random gaps.
module tb_prog_loader;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2048;
    localparam int TMO    = 40;

    logic              clk = 1'b0;
    logic              reset_ = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy, done, err;
    logic [1:0]        err_code;

    prog_loader #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .reset_    (reset_),
        .start     (start),
        .abort     (abort),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position within the frame (0,1 = length, then 4N data bytes, then checksum)
    bit                m_act;
    int                m_pos, m_n, m_idle;
    logic [7:0]        m_hi, m_sum;
    logic [31:0]       m_w;
    logic              e_busy, e_done, e_err, e_we;
    logic [1:0]        e_code;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0]       e_wdata;

    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            m_act = 0; m_pos = 0; m_n = 0; m_idle = 0; m_hi = 0; m_sum = 0; m_w = 0;
            e_busy = 0; e_done = 0; e_err = 0; e_we = 0; e_code = 0; e_addr = 0; e_wdata = 0;
        end else begin
            e_we = 0;
            if (abort) begin
                m_act = 0; e_done = 0; e_err = 0; e_code = 0;
            end else if (!m_act) begin
                if (start) begin
                    m_act = 1; m_pos = 0; m_sum = 0; m_idle = 0; m_w = 0;
                    e_done = 0; e_err = 0; e_code = 0;
                end
            end else if (rx_valid) begin
                m_idle = 0;
                if (m_pos == 0) begin
                    m_hi = rx_data;
                end else if (m_pos == 1) begin
                    m_n = {m_hi, rx_data};
                    if (m_n < 1 || m_n > DEPTH) begin
                        m_act = 0; e_err = 1; e_code = 2'b01;
                    end
                end else if (m_pos < 2 + 4 * m_n) begin
                    m_sum = m_sum + rx_data;
                    m_w = {m_w[23:0], rx_data};
                    if ((m_pos - 2) % 4 == 3) begin
                        e_we = 1; e_addr = ADDR_W'((m_pos - 2) / 4); e_wdata = m_w;
                    end
                end else begin
                    m_act = 0;
                    if (8'(m_sum + rx_data) == 8'h00) e_done = 1;
                    else begin e_err = 1; e_code = 2'b10; end
                end
                m_pos++;
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_act = 0; e_err = 1; e_code = 2'b11;
                end
            end
            e_busy = m_act;
        end
    end

    // Per-cycle comparison against the model, plus a shadow image of memory writes
    logic [31:0]       mem_img [0:DEPTH-1];
    int                wr_cnt = 0;
    logic [ADDR_W-1:0] last_addr = '0;

    always @(negedge clk) begin
        if (reset_) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("err", 32'(err), 32'(e_err));
            chk("err_code", 32'(err_code), 32'(e_code));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_wdata", mem_wdata, e_wdata);
            if (mem_we) begin
                mem_img[mem_addr] = mem_wdata;
                wr_cnt++;
                last_addr = mem_addr;
            end
        end
    end

    logic [7:0] seq[$];

    task automatic idle_cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_seq(input int gap_max);
        foreach (seq[i]) begin
            idle_cycles($urandom_range(0, gap_max));
            send_byte(seq[i]);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_code"}, 32'(err_code), 32'h0);
        chk({tag, "_we"}, 32'(mem_we), 32'h0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        int w0, n, kind, abort_at, stall_at, stall_len, gap;
        logic [7:0] s, b;

        #1;
        chk_reset_outputs("rst");
        idle_cycles(3);
        reset_ = 1'b1;
        idle_cycles(2);

        // Two words; checksum 0x9C makes the data sum wrap to zero
        w0 = wr_cnt;
        pulse_start();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        chk("w0_lat_we", 32'(mem_we), 32'h1);
        chk("w0_lat_addr", 32'(mem_addr), 32'h0);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        chk("w1_lat_we", 32'(mem_we), 32'h1);
        chk("w1_lat_data", mem_wdata, 32'h55667788);
        send_byte(8'h9C);
        idle_cycles(3);
        chk("tp1_done", 32'(done), 32'h1);
        chk("tp1_code", 32'(err_code), 32'h0);
        chk("tp1_img0", mem_img[0], 32'h11223344);
        chk("tp1_img1", mem_img[1], 32'h55667788);
        chk("tp1_nwr", 32'(wr_cnt - w0), 32'd2);
        chk("pin_model_done", 32'(e_done), 32'h1);

        // Zero and oversize lengths
        w0 = wr_cnt;
        pulse_start(); send_byte(8'h00); send_byte(8'h00); idle_cycles(2);
        chk("len0_err", 32'(err), 32'h1);
        chk("len0_code", 32'(err_code), 32'h1);
        pulse_start(); send_byte(8'h08); send_byte(8'h01); idle_cycles(2);
        chk("len801_code", 32'(err_code), 32'h1);
        chk("pin_model_len", 32'(e_code), 32'h1);
        chk("len_nwr", 32'(wr_cnt - w0), 32'd0);

        // Wrong checksum after one good word
        pulse_start();
        seq = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
        send_seq(2); idle_cycles(3);
        chk("csum_img0", mem_img[0], 32'hDEADBEEF);
        chk("csum_err", 32'(err), 32'h1);
        chk("csum_code", 32'(err_code), 32'h2);

        // Full-length stall times out; one cycle shorter survives
        pulse_start();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hDE); send_byte(8'hAD);
        idle_cycles(TMO);
        chk("tmo_err", 32'(err), 32'h1);
        chk("tmo_code", 32'(err_code), 32'h3);
        pulse_start();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hDE); send_byte(8'hAD);
        idle_cycles(TMO - 1);
        send_byte(8'hBE); send_byte(8'hEF); send_byte(8'hC8);
        idle_cycles(2);
        chk("notmo_done", 32'(done), 32'h1);

        // Abort after six data bytes
        w0 = wr_cnt;
        pulse_start();
        seq = '{8'h00, 8'h02, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
        send_seq(1);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_err", 32'(err), 32'h0);
        idle_cycles(2);
        chk("abort_nwr", 32'(wr_cnt - w0), 32'd1);
        chk("abort_img0", mem_img[0], 32'hA1A2A3A4);
        // Bytes in IDLE are ignored; start while busy is ignored
        send_byte(8'h00); send_byte(8'h01); idle_cycles(2);
        chk("idle_rx_busy", 32'(busy), 32'h0);
        chk("idle_rx_nwr", 32'(wr_cnt - w0), 32'd1);
        pulse_start(); send_byte(8'h00); pulse_start();
        seq = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
        send_seq(0); idle_cycles(2);
        chk("reload_img0", mem_img[0], 32'h01020304);
        chk("reload_done", 32'(done), 32'h1);

        // Reset mid-word
        pulse_start();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
        #2 reset_ = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(negedge clk); reset_ = 1'b1;
        idle_cycles(1);
        pulse_start();
        seq = '{8'h00, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h60};
        send_seq(0); idle_cycles(2);
        chk("postrst_img0", mem_img[0], 32'h10203040);
        chk("postrst_done", 32'(done), 32'h1);

        // Maximum length: last write lands on DEPTH-1
        w0 = wr_cnt; s = 8'h00;
        seq.delete(); seq.push_back(8'h08); seq.push_back(8'h00);
        for (int i = 0; i < 4 * DEPTH; i++) begin
            b = 8'($urandom); s = s + b; seq.push_back(b);
        end
        seq.push_back(8'(-s));
        pulse_start(); send_seq(0); idle_cycles(2);
        chk("max_nwr", 32'(wr_cnt - w0), 32'(DEPTH));
        chk("max_last_addr", 32'(last_addr), 32'(DEPTH - 1));
        chk("max_done", 32'(done), 32'h1);

        // Random frames: good, bad length, bad checksum, aborts, stalls, stray starts/bytes
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) n = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(DEPTH + 1, 65535);
            else n = $urandom_range(1, 6);
            seq.delete(); seq.push_back(n[15:8]); seq.push_back(n[7:0]);
            s = 8'h00;
            if (kind != 0) begin
                for (int i = 0; i < 4 * n; i++) begin
                    b = 8'($urandom); s = s + b; seq.push_back(b);
                end
                b = 8'(-s);
                if (kind == 2) b = b + 8'($urandom_range(1, 255));
                seq.push_back(b);
            end
            abort_at  = (kind == 3) ? $urandom_range(1, seq.size() - 1) : -1;
            stall_at  = (kind == 4) ? $urandom_range(1, seq.size() - 1) : -1;
            stall_len = ($urandom_range(0, 1) == 1) ? TMO : TMO - 1;
            if (kind == 6) begin send_byte(8'($urandom)); send_byte(8'($urandom)); end
            pulse_start();
            foreach (seq[i]) begin
                gap = (i == stall_at) ? stall_len : $urandom_range(0, 3);
                idle_cycles(gap);
                if (gap >= TMO) break;
                if (i == abort_at) begin
                    abort = 1'b1; @(negedge clk); abort = 1'b0;
                    break;
                end
                if (kind == 5 && i == 1) pulse_start();
                send_byte(seq[i]);
            end
            idle_cycles(3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
